// File: rtl/hazard_scoreboard.sv
// Load-use hazard scoreboard: one down-counter per register tracks outstanding
// loads and stalls the IF/ID instruction until its sources are forwardable.
module hazard_scoreboard #(
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int LOAD_LAT = 2,
  parameter int SCW      = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [AW-1:0]   id_rs1,
  input  logic [AW-1:0]   id_rs2,
  input  logic            id_rs1_en,
  input  logic            id_rs2_en,
  input  logic [AW-1:0]   id_rd,
  input  logic            id_mem_read,
  input  logic            id_reg_write,
  input  logic            flush,
  output logic            stall,
  output logic            pc_en,
  output logic            if_id_en,
  output logic            id_ex_bubble,
  output logic [NREG-1:0] pending,
  output logic [SCW-1:0]  stall_cycles
);

  localparam int CW = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(LOAD_LAT);

  logic issue;
  logic loadIssue;
  logic rs1Hit;
  logic rs2Hit;

  // Indices outside the register file never match, so they read as not pending.
  function automatic logic isPending(input logic [AW-1:0] idx, input logic [NREG-1:0] pend);
    isPending = 1'b0;
    for (int i = 1; i < NREG; i++)
      if (idx == AW'(i)) isPending = pend[i];
  endfunction

  always_comb begin
    rs1Hit = id_rs1_en & isPending(id_rs1, pending);
    rs2Hit = id_rs2_en & isPending(id_rs2, pending);
    stall  = id_valid & ~flush & (rs1Hit | rs2Hit);
  end

  assign issue        = id_valid & ~stall & ~flush;
  assign loadIssue    = issue & id_mem_read & id_reg_write;
  assign pc_en        = ~stall;
  assign if_id_en     = ~stall;
  assign id_ex_bubble = stall | flush;

  assign pending[0] = 1'b0;

  for (genvar g = 1; g < NREG; g++) begin : gCnt
    logic [CW-1:0] cntQ;
    logic          loadHit;

    assign loadHit    = loadIssue & (id_rd == AW'(g));
    assign pending[g] = (cntQ != '0);

    // A new load to the same register restarts the countdown.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)                cntQ <= '0;
      else if (loadHit)        cntQ <= LOAD_VAL;
      else if (cntQ != '0)     cntQ <= cntQ - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             stall_cycles <= '0;
    else if (stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + SCW'(1);
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: default instance plus a LOAD_LAT=1 and
// an SCW=2 instance sharing the same instruction stream.
module tb_hazard_scoreboard;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, id_rs1_en, id_rs2_en, id_mem_read, id_reg_write, flush;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;

  logic            stall, pcEn, ifIdEn, bubble;
  logic [NREG-1:0] pending;
  logic [15:0]     stallCycles;

  logic            stallL1, pcEnL1, ifIdEnL1, bubbleL1;
  logic [NREG-1:0] pendingL1;
  logic [15:0]     stallCyclesL1;

  logic            stallS2, pcEnS2, ifIdEnS2, bubbleS2;
  logic [NREG-1:0] pendingS2;
  logic [1:0]      stallCyclesS2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.NREG(NREG), .AW(AW), .LOAD_LAT(2), .SCW(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en), .id_rd(id_rd),
    .id_mem_read(id_mem_read), .id_reg_write(id_reg_write), .flush(flush),
    .stall(stall), .pc_en(pcEn), .if_id_en(ifIdEn), .id_ex_bubble(bubble),
    .pending(pending), .stall_cycles(stallCycles));

  hazard_scoreboard #(.NREG(NREG), .AW(AW), .LOAD_LAT(1), .SCW(16)) uLat1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en), .id_rd(id_rd),
    .id_mem_read(id_mem_read), .id_reg_write(id_reg_write), .flush(flush),
    .stall(stallL1), .pc_en(pcEnL1), .if_id_en(ifIdEnL1), .id_ex_bubble(bubbleL1),
    .pending(pendingL1), .stall_cycles(stallCyclesL1));

  hazard_scoreboard #(.NREG(NREG), .AW(AW), .LOAD_LAT(2), .SCW(2)) uScw2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en), .id_rd(id_rd),
    .id_mem_read(id_mem_read), .id_reg_write(id_reg_write), .flush(flush),
    .stall(stallS2), .pc_en(pcEnS2), .if_id_en(ifIdEnS2), .id_ex_bubble(bubbleS2),
    .pending(pendingS2), .stall_cycles(stallCyclesS2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] r1, input logic e1,
                       input logic [AW-1:0] r2, input logic e2, input logic [AW-1:0] rd,
                       input logic mr, input logic rw, input logic fl);
    id_valid = v; id_rs1 = r1; id_rs1_en = e1; id_rs2 = r2; id_rs2_en = e2;
    id_rd = rd; id_mem_read = mr; id_reg_write = rw; flush = fl;
  endtask

  task automatic idle();          drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); endtask
  task automatic load(input logic [AW-1:0] rd);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, rd, 1'b1, 1'b1, 1'b0);
  endtask
  task automatic reader(input logic [AW-1:0] rs);
    drive(1'b1, rs, 1'b1, 5'd0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0);
  endtask
  task automatic indep();         drive(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0); endtask

  initial begin
    rst = 1'b0;
    idle();
    #2;
    chk("rst_pending", pending, 0);
    chk("rst_stall", stall, 0);
    chk("rst_pc_en", pcEn, 1);
    chk("rst_if_id_en", ifIdEn, 1);
    chk("rst_bubble", bubble, 0);
    chk("rst_stall_cycles", stallCycles, 0);
    flush = 1'b1;
    #1 chk("rst_bubble_flush", bubble, 1);
    flush = 1'b0;
    @(negedge clk) rst = 1'b1;

    // Load x5 followed immediately by a reader
    @(negedge clk) load(5'd5);
    #1 chk("lu_load_stall", stall, 0);
    @(negedge clk) reader(5'd5);
    #1 chk("lu_stall1", stall, 1);
    chk("lu_bubble1", bubble, 1);
    chk("lu_pc_en1", pcEn, 0);
    chk("lu_if_id_en1", ifIdEn, 0);
    chk("lu_pending5", pending, 32'h20);
    chk("lat1_stall1", stallL1, 1);
    @(negedge clk);
    #1 chk("lu_stall2", stall, 1);
    chk("lu_bubble2", bubble, 1);
    chk("lat1_stall2", stallL1, 0);
    chk("lat1_stall_cycles", stallCyclesL1, 1);
    @(negedge clk);
    #1 chk("lu_stall3", stall, 0);
    chk("lu_bubble3", bubble, 0);
    chk("lu_pending_clear", pending, 0);
    chk("lu_stall_cycles", stallCycles, 2);
    chk("scw2_stall_cycles", stallCyclesS2, 2);
    @(negedge clk) idle();

    // One independent instruction in between
    @(negedge clk) load(5'd5);
    @(negedge clk) indep();
    #1 chk("gap1_indep_stall", stall, 0);
    @(negedge clk) reader(5'd5);
    #1 chk("gap1_stall1", stall, 1);
    @(negedge clk);
    #1 chk("gap1_stall2", stall, 0);
    chk("gap1_stall_cycles", stallCycles, 3);

    // Two independent instructions in between
    @(negedge clk) load(5'd5);
    @(negedge clk) indep();
    @(negedge clk) indep();
    @(negedge clk) reader(5'd5);
    #1 chk("gap2_stall", stall, 0);

    // x0 loads and disabled sources never stall
    @(negedge clk) load(5'd0);
    @(negedge clk) reader(5'd0);
    #1 chk("x0_stall", stall, 0);
    chk("x0_pending", pending, 0);
    @(negedge clk) load(5'd5);
    @(negedge clk) drive(1'b1, 5'd7, 1'b1, 5'd5, 1'b0, 5'd8, 1'b0, 1'b1, 1'b0);
    #1 chk("rs2dis_stall", stall, 0);
    chk("rs2dis_pending", pending, 32'h20);
    @(negedge clk) idle();
    @(negedge clk);
    #1 chk("rs2dis_drain", pending, 0);

    // Flush on a stalled reader that is itself a load to x6
    @(negedge clk) load(5'd5);
    @(negedge clk) drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b1);
    #1 chk("flush_stall", stall, 0);
    chk("flush_bubble", bubble, 1);
    chk("flush_pc_en", pcEn, 1);
    @(negedge clk) idle();
    #1 chk("flush_pending", pending, 32'h20);
    @(negedge clk);
    #1 chk("flush_drain", pending, 0);
    chk("flush_stall_cycles", stallCycles, 3);

    // Back-to-back loads to x5 restart the countdown
    @(negedge clk) load(5'd5);
    @(negedge clk) load(5'd5);
    #1 chk("b2b_load_stall", stall, 0);
    @(negedge clk) reader(5'd5);
    #1 chk("b2b_stall1", stall, 1);
    @(negedge clk);
    #1 chk("b2b_stall2", stall, 1);
    @(negedge clk);
    #1 chk("b2b_stall3", stall, 0);
    chk("b2b_stall_cycles", stallCycles, 5);
    chk("scw2_saturate", stallCyclesS2, 3);

    // Asynchronous reset in the middle of a stall
    @(negedge clk) idle();
    @(negedge clk) load(5'd5);
    @(negedge clk) reader(5'd5);
    #1 chk("arst_pre_stall", stall, 1);
    chk("arst_pre_pending", pending, 32'h20);
    rst = 1'b0;
    #1 chk("arst_pending", pending, 0);
    chk("arst_stall", stall, 0);
    chk("arst_pc_en", pcEn, 1);
    chk("arst_bubble", bubble, 0);
    chk("arst_stall_cycles", stallCycles, 0);
    @(negedge clk) begin idle(); rst = 1'b1; end
    @(negedge clk);
    #1 chk("arst_post_pending", pending, 0);
    chk("arst_post_stall", stall, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
